// File: rtl/phy_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : phy_mem_arbiter_pkg
// Description : Shared encodings and constants for the physical memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package phy_mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE     = 2'd0;
    localparam logic [1:0] ARB_RD_WAIT  = 2'd1;
    localparam logic [1:0] ARB_WR_PULSE = 2'd2;
    localparam logic [1:0] ARB_WR_WAIT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ARB_IDLE,
        ST_RD_WAIT  = ARB_RD_WAIT,
        ST_WR_PULSE = ARB_WR_PULSE,
        ST_WR_WAIT  = ARB_WR_WAIT
    } arb_state_t;

    localparam int PORT_DATA   = 0;
    localparam int PORT_IFETCH = 1;
    localparam int PORT_DMA    = 2;

    // Idle address must decode to RAM so parked cycles have no device side effects.
    localparam logic [31:0] DEFAULT_PARK_ADDR = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin search starting after rr_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import phy_mem_arbiter_pkg::*;
#(
    parameter int NPORTS = 3
) (
    input  logic [NPORTS-1:0] eligible,
    input  logic [2:0]        rr_ptr,
    output logic [2:0]        winner,
    output logic              valid
);

    localparam int c_iw = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    int              w_sum;
    logic [c_iw-1:0] w_idx;

    // Walk from the farthest offset down so the nearest eligible port wins last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_sum  = 0;
        w_idx  = '0;
        for (int off = NPORTS; off >= 1; off--) begin
            w_sum = int'(rr_ptr) + off;
            if (w_sum >= NPORTS) begin
                w_sum = w_sum - NPORTS;
            end
            w_idx = c_iw'(w_sum);
            if (eligible[w_idx]) begin
                winner = 3'(w_idx);
                valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/phy_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : phy_mem_arbiter
// Description : Round-robin arbiter sharing one physical memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
module phy_mem_arbiter
    import phy_mem_arbiter_pkg::*;
#(
    parameter int          NPORTS           = 3,
    parameter int          READ_WAIT_CYCLES = 1,
    parameter logic [31:0] PARK_ADDR        = DEFAULT_PARK_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    port_req,
    input  logic [NPORTS-1:0]    port_we,
    input  logic [NPORTS*32-1:0] port_addr,
    input  logic [NPORTS*32-1:0] port_wdata,
    output logic [NPORTS-1:0]    port_ack,
    output logic [31:0]          port_rdata,
    output logic [2:0]           grant_id,
    output logic                 arb_busy,
    output logic                 err_unaligned,
    output logic                 phy_is_write,
    output logic [31:0]          phy_addr,
    output logic [31:0]          phy_data_in,
    input  logic [31:0]          phy_data_out,
    input  logic                 phy_busy
);

    localparam int              c_cw       = (READ_WAIT_CYCLES > 1) ? $clog2(READ_WAIT_CYCLES) : 1;
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(READ_WAIT_CYCLES - 1);
    localparam logic [31:0]     c_park     = word_align(PARK_ADDR);

    arb_state_t        r_state,      w_state_n;
    logic [2:0]        r_rr_ptr,     w_rr_ptr_n;
    logic [c_cw-1:0]   r_cnt,        w_cnt_n;
    logic [NPORTS-1:0] r_ack,        w_ack_n;
    logic [31:0]       r_rdata,      w_rdata_n;
    logic [2:0]        r_grant,      w_grant_n;
    logic              r_arb_busy,   w_arb_busy_n;
    logic              r_err,        w_err_n;
    logic              r_phy_we,     w_phy_we_n;
    logic [31:0]       r_phy_addr,   w_phy_addr_n;
    logic [31:0]       r_phy_wdata,  w_phy_wdata_n;

    logic [NPORTS-1:0] w_eligible;
    logic [NPORTS-1:0] w_grant_oh;
    logic [2:0]        w_winner;
    logic              w_valid;
    logic              w_sel_we;
    logic [31:0]       w_sel_addr;
    logic [31:0]       w_sel_wdata;

    // A port acked this cycle still shows its old request; never re-grant it.
    assign w_eligible = port_req & ~r_ack;

    rr_picker #(
        .NPORTS (NPORTS)
    ) u_rr_picker (
        .eligible (w_eligible),
        .rr_ptr   (r_rr_ptr),
        .winner   (w_winner),
        .valid    (w_valid)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_grant_oh  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_winner == 3'(i)) begin
                w_sel_we    = port_we[i];
                w_sel_addr  = port_addr[32*i +: 32];
                w_sel_wdata = port_wdata[32*i +: 32];
            end
            w_grant_oh[i] = (r_grant == 3'(i));
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_rr_ptr_n    = r_rr_ptr;
        w_cnt_n       = r_cnt;
        w_ack_n       = '0;
        w_rdata_n     = r_rdata;
        w_grant_n     = r_grant;
        w_err_n       = r_err;
        w_phy_we_n    = 1'b0;
        w_phy_addr_n  = r_phy_addr;
        w_phy_wdata_n = r_phy_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_grant_n     = w_winner;
                    w_rr_ptr_n    = w_winner;
                    w_phy_addr_n  = word_align(w_sel_addr);
                    w_phy_wdata_n = w_sel_wdata;
                    if (w_sel_addr[1:0] != 2'b00) begin
                        w_err_n = 1'b1;
                    end
                    if (w_sel_we) begin
                        w_state_n  = ST_WR_PULSE;
                        w_phy_we_n = 1'b1;
                    end else begin
                        w_state_n = ST_RD_WAIT;
                        w_cnt_n   = '0;
                    end
                end else begin
                    w_phy_addr_n = c_park;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == c_cnt_last) begin
                    if (!phy_busy) begin
                        w_rdata_n    = phy_data_out;
                        w_ack_n      = w_grant_oh;
                        w_phy_addr_n = c_park;
                        w_state_n    = ST_IDLE;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            ST_WR_PULSE: begin
                w_state_n = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (!phy_busy) begin
                    w_ack_n      = w_grant_oh;
                    w_phy_addr_n = c_park;
                    w_state_n    = ST_IDLE;
                end
            end
            default: begin
                w_state_n    = ST_IDLE;
                w_phy_addr_n = c_park;
            end
        endcase

        w_arb_busy_n = (w_state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_grant     <= '0;
            r_arb_busy  <= 1'b0;
            r_err       <= 1'b0;
            r_phy_we    <= 1'b0;
            r_phy_addr  <= c_park;
            r_phy_wdata <= '0;
        end else begin
            r_state     <= w_state_n;
            r_rr_ptr    <= w_rr_ptr_n;
            r_cnt       <= w_cnt_n;
            r_ack       <= w_ack_n;
            r_rdata     <= w_rdata_n;
            r_grant     <= w_grant_n;
            r_arb_busy  <= w_arb_busy_n;
            r_err       <= w_err_n;
            r_phy_we    <= w_phy_we_n;
            r_phy_addr  <= w_phy_addr_n;
            r_phy_wdata <= w_phy_wdata_n;
        end
    end

    assign port_ack      = r_ack;
    assign port_rdata    = r_rdata;
    assign grant_id      = r_grant;
    assign arb_busy      = r_arb_busy;
    assign err_unaligned = r_err;
    assign phy_is_write  = r_phy_we;
    assign phy_addr      = r_phy_addr;
    assign phy_data_in   = r_phy_wdata;

endmodule
`default_nettype wire

// File: doc/phy_mem_arbiter.md
Name: phy_mem_arbiter

Overview:
- Shares the single physical memory controller (the is_write/addr/data_in/data_out/busy bus) among NPORTS requesters.
- Default port map: 0 = CPU data (MEM stage), 1 = CPU instruction fetch, 2 = DMA/block-copy engine.
- Serialises requests with round-robin arbitration and turns each request into a clean controller transaction:
  - read: address held for a fixed settle window;
  - write: a single-cycle is_write pulse, so the controller's edge detector always sees a fresh rising edge.
- Returns a one-cycle ack plus read data to the winning port.

Parameters:
- NPORTS, 3, number of requester ports (2..8).
- READ_WAIT_CYCLES, 1, cycles phy_addr is held before phy_data_out is sampled (≥1; set 3 for flash-heavy systems).
- PARK_ADDR, 32'h00000000, address driven to the controller when idle. Must be RAM, so idle cycles cause no serial/keyboard interrupt-ack side effects.

Ports:
- clk  in  1  system clock; arbiter logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- port_req  in  NPORTS  request per port; held high with fields stable until that port's ack.
- port_we  in  NPORTS  1 = write, 0 = read.
- port_addr  in  NPORTS*32  byte address per port; port i occupies bits [32i+31:32i].
- port_wdata  in  NPORTS*32  write data per port.
- port_ack  out  NPORTS  one-hot, one-cycle completion pulse.
- port_rdata  out  32  read data; valid in the ack cycle of a read.
- grant_id  out  3  index of the port owning the current or last transaction.
- arb_busy  out  1  high whenever state != IDLE.
- err_unaligned  out  1  sticky; set when a granted request has addr[1:0] != 0; cleared only by rst.
- phy_is_write  out  1  to controller is_write.
- phy_addr  out  32  to controller addr; bits [1:0] always 0.
- phy_data_in  out  32  to controller data_in.
- phy_data_out  in  32  from controller data_out.
- phy_busy  in  1  from controller busy.

Behaviour:
- Reset values:
  - state IDLE, rr_ptr 0;
  - port_ack 0, port_rdata 0, grant_id 0, arb_busy 0, err_unaligned 0;
  - phy_is_write 0, phy_addr PARK_ADDR, phy_data_in 0.
  - All outputs are registered.
- States: IDLE, RD_WAIT, WR_PULSE, WR_WAIT.
- IDLE:
  - Eligible ports: req[i]=1 and port_ack[i]=0. A port acked this cycle is skipped, so its stale request is never re-granted.
  - Winner = first eligible index searching rr_ptr+1, rr_ptr+2, … modulo NPORTS.
  - On a grant:
    - latch we, addr (bits [1:0] forced to 0) and wdata;
    - grant_id <= winner, rr_ptr <= winner;
    - set err_unaligned if addr[1:0] != 0 (the transaction still proceeds, word-aligned);
    - next state: RD_WAIT with cnt=0 if read, otherwise WR_PULSE.
  - No request: phy_addr stays PARK_ADDR.
- RD_WAIT:
  - phy_addr = latched addr; cnt increments each cycle.
  - When cnt == READ_WAIT_CYCLES-1 and phy_busy == 0:
    - port_rdata <= phy_data_out, port_ack[grant] <= 1;
    - phy_addr <= PARK_ADDR, state IDLE.
  - If phy_busy is high, cnt saturates and the state waits.
- WR_PULSE:
  - phy_is_write = 1, phy_addr/phy_data_in = latched values, for exactly one cycle.
  - Next state WR_WAIT.
- WR_WAIT:
  - phy_is_write = 0; address and data stay held.
  - When phy_busy == 0: port_ack[grant] <= 1, phy_addr <= PARK_ADDR, state IDLE.
  - Guarantees is_write is low for ≥1 cycle between consecutive writes.
- Latency, request seen in cycle N:
  - read ack in N+1+READ_WAIT_CYCLES (N+2 by default);
  - write ack at earliest N+3; extended while phy_busy is high (RAM/flash write windows).
- Throughput: one transaction in flight; no pipelining.
- Requester drops req mid-transaction: the transaction still completes on the controller and the ack is still issued (latched request).
- Simultaneous requests: exactly one grant per IDLE cycle; round-robin bounds waiting to NPORTS-1 transactions.
- rst mid-operation: immediate return to IDLE with reset values, no ack issued; an in-flight write may be partially performed.
- phy_busy is never sampled in IDLE or WR_PULSE.

Decomposition:
- Shared package:
  - state encoding localparams: ARB_IDLE, ARB_RD_WAIT, ARB_WR_PULSE, ARB_WR_WAIT;
  - port index constants: PORT_DATA=0, PORT_IFETCH=1, PORT_DMA=2;
  - PARK_ADDR default.
- One sub-module: rr_picker (combinational round-robin search, inputs eligible[NPORTS] and rr_ptr; outputs winner and valid). Reused by the interrupt controller.

Test Plan:
- Single read: port1 read 0x00000100, phy_data_out=0xDEADBEEF → port_ack=3'b010 two cycles later, port_rdata=0xDEADBEEF; phy_is_write never high.
- RAM write with busy: port0 write 0x00000040 ← 0x12345678, phy_busy high 3 cycles after the pulse → exactly one phy_is_write pulse; ack when busy falls; phy_addr/data held until ack.
- Contention: all 3 ports request reads from reset → grants in order 1,2,0, then 1 again if it re-requests; no port is granted twice in consecutive transactions while others wait.
- Back-to-back writes: port2 issues two writes (serial port 0x1FD003F8) → two distinct is_write pulses separated by ≥1 low cycle; two acks.
- Reset mid-write: rst asserted during WR_WAIT → next cycle state IDLE, phy_is_write 0, phy_addr=PARK_ADDR, no ack.
- Unaligned/slow read: READ_WAIT_CYCLES=3, read of 0x1E000002 → phy_addr=0x1E000000 held 3 cycles, err_unaligned=1 and sticky until rst.
